// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Optional round-robin mode is selected with the MEM_ARB_RR_EN macro.
package mem_arb_pkg;

   localparam int unsigned DEF_ADDR_W   = 16;
   localparam int unsigned DEF_DATA_W   = 16;
   localparam int unsigned DEF_MAX_WAIT = 4;

   // Wide enough for the largest legal MAX_WAIT (15).
   localparam int unsigned WAIT_W = 4;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   typedef enum logic [0:0] {
      ST_OPEN,
      ST_LOCKED
   } state_e;

endpackage

// File: rtl/mem_arb_wait_ctr.sv
// Saturating stall counter for port A; sat flags that A has waited MAX cycles.
// Only used when MEM_ARB_RR_EN is undefined.
module mem_arb_wait_ctr
   import mem_arb_pkg::*;
#(
   parameter int unsigned MAX = DEF_MAX_WAIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam logic [WAIT_W-1:0] MaxCnt = WAIT_W'(MAX);

   logic [WAIT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != MaxCnt)) begin
         cnt_d = cnt_q + WAIT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sat = (cnt_q == MaxCnt);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port word memory with 1-cycle responses.
// Define MEM_ARB_RR_EN for round-robin in the open state instead of B-priority + starvation.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   output logic              a_ready,
   output logic              a_rsp_valid,
   output logic [DATA_W-1:0] a_rsp_data,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   input  logic              b_lock,
   output logic              b_ready,
   output logic              b_rsp_valid,
   output logic [DATA_W-1:0] b_rsp_data,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_write_enable,
   output logic              mem_read_enable,
   input  logic [DATA_W-1:0] mem_read_data
);

   state_e            state_q, state_d;
   logic              a_gnt, b_gnt;
   logic              a_rsp_valid_q, a_rsp_valid_d;
   logic              b_rsp_valid_q, b_rsp_valid_d;
   logic [DATA_W-1:0] a_rsp_data_q, a_rsp_data_d;
   logic [DATA_W-1:0] b_rsp_data_q, b_rsp_data_d;

`ifdef MEM_ARB_RR_EN
   logic last_q, last_d;

   // Lock holds off A entirely; otherwise ties go to whoever was not granted last.
   always_comb begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
      if (state_q == ST_LOCKED) begin
         b_gnt = b_req;
      end else if (a_req && b_req) begin
         if (last_q == PORT_B) begin
            a_gnt = 1'b1;
         end else begin
            b_gnt = 1'b1;
         end
      end else begin
         a_gnt = a_req;
         b_gnt = b_req;
      end
   end

   always_comb begin
      last_d = last_q;
      if (a_gnt) begin
         last_d = PORT_A;
      end else if (b_gnt) begin
         last_d = PORT_B;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= PORT_B;
      end else begin
         last_q <= last_d;
      end
   end
`else
   logic wait_sat;

   // Counter keeps saturating while locked so A is served as soon as the lock drops.
   mem_arb_wait_ctr #(
      .MAX (MAX_WAIT)
   ) u_wait_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (a_req & ~a_gnt),
      .clr   (~a_req | a_gnt),
      .sat   (wait_sat)
   );

   always_comb begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
      if (state_q == ST_LOCKED) begin
         b_gnt = b_req;
      end else if (a_req && wait_sat) begin
         a_gnt = 1'b1;
      end else if (b_req) begin
         b_gnt = 1'b1;
      end else begin
         a_gnt = a_req;
      end
   end
`endif

   assign a_ready = a_gnt;
   assign b_ready = b_gnt;

   always_comb begin
      mem_address      = '0;
      mem_data         = '0;
      mem_write_enable = 1'b0;
      mem_read_enable  = 1'b0;
      if (a_gnt) begin
         mem_address     = a_addr;
         mem_read_enable = 1'b1;
      end else if (b_gnt) begin
         mem_address      = b_addr;
         mem_write_enable = b_we;
         mem_read_enable  = ~b_we;
         mem_data         = b_we ? b_wdata : '0;
      end
   end

   always_comb begin
      state_d       = state_q;
      a_rsp_valid_d = a_gnt;
      b_rsp_valid_d = b_gnt;
      a_rsp_data_d  = a_rsp_data_q;
      b_rsp_data_d  = b_rsp_data_q;
      if (a_gnt) begin
         a_rsp_data_d = mem_read_data;
      end
      if (b_gnt) begin
         b_rsp_data_d = b_we ? '0 : mem_read_data;
         state_d      = b_lock ? ST_LOCKED : ST_OPEN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_OPEN;
         a_rsp_valid_q <= 1'b0;
         b_rsp_valid_q <= 1'b0;
         a_rsp_data_q  <= '0;
         b_rsp_data_q  <= '0;
      end else begin
         state_q       <= state_d;
         a_rsp_valid_q <= a_rsp_valid_d;
         b_rsp_valid_q <= b_rsp_valid_d;
         a_rsp_data_q  <= a_rsp_data_d;
         b_rsp_data_q  <= b_rsp_data_d;
      end
   end

   assign a_rsp_valid = a_rsp_valid_q;
   assign b_rsp_valid = b_rsp_valid_q;
   assign a_rsp_data  = a_rsp_data_q;
   assign b_rsp_data  = b_rsp_data_q;

   a_b_exclusive : assert property (@(posedge clk) disable iff (!rst_n) !(a_ready && b_ready));

endmodule
